// File: rtl/aes_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_pkg -- shared constants, FSM encoding and round-key slicing for the
//            AES-128 round sequencer.                          Revision 1.0
// ---------------------------------------------------------------------------
package aes_pkg;

  localparam int NR      = 10;
  localparam int STATE_W = 128;
  localparam int EKEY_W  = 1408;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_ISSUE = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    FSM_IDLE  = ST_IDLE,
    FSM_ISSUE = ST_ISSUE,
    FSM_WAIT  = ST_WAIT,
    FSM_DONE  = ST_DONE
  } fsm_e;

  // Indices above NR return zero rather than reading past the key schedule.
  function automatic logic [STATE_W-1:0] round_key(
    input logic [EKEY_W-1:0] ekey,
    input logic [3:0]        idx
  );
    logic [STATE_W-1:0] key;
    key = '0;
    for (int k = 0; k <= NR; k++) begin
      if (idx == 4'(k)) begin
        key = ekey[EKEY_W-1-STATE_W*k -: STATE_W];
      end
    end
    return key;
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_round_key_sel.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_round_key_sel -- registered 11:1 round-key mux from the expanded key.
//                                                             Revision 1.0
// ---------------------------------------------------------------------------
module aes_round_key_sel
  import aes_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic [EKEY_W-1:0]  expanded_key,
  input  logic [3:0]         idx,
  output logic [STATE_W-1:0] rnd_key
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rnd_key <= '0;
    end else begin
      rnd_key <= round_key(expanded_key, idx);
    end
  end

endmodule
`default_nettype wire

// File: rtl/aes_round_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// aes_round_ctrl -- sequencer for an iterative AES-128 encrypt round datapath.
//                                                             Revision 1.0
// ---------------------------------------------------------------------------
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int RND_LAT = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [STATE_W-1:0] plaintext,
  input  logic [EKEY_W-1:0]  expanded_key,
  input  logic               abort,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [STATE_W-1:0] ciphertext,
  output logic               busy,
  output logic [3:0]         round_idx,
  output logic               rnd_valid,
  output logic [STATE_W-1:0] rnd_state,
  output logic [STATE_W-1:0] rnd_key,
  output logic               rnd_last,
  input  logic [STATE_W-1:0] rnd_result
);

  localparam logic [3:0] WAIT_INIT = 4'(RND_LAT - 1);
  localparam logic [3:0] LAST_RND  = 4'(NR);

  fsm_e               fsm_q, fsm_d;
  logic [STATE_W-1:0] state_q, state_d;
  logic [3:0]         round_idx_d;
  logic [3:0]         wait_cnt_q, wait_cnt_d;

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    round_idx_d = round_idx;
    wait_cnt_d  = wait_cnt_q;
    case (fsm_q)
      FSM_IDLE: begin
        if (in_valid && !abort) begin
          state_d     = plaintext ^ round_key(expanded_key, 4'd0);
          round_idx_d = 4'd1;
          fsm_d       = FSM_ISSUE;
        end
      end
      FSM_ISSUE: begin
        wait_cnt_d = WAIT_INIT;
        fsm_d      = FSM_WAIT;
      end
      FSM_WAIT: begin
        if (wait_cnt_q != 4'd0) begin
          wait_cnt_d = wait_cnt_q - 4'd1;
        end else begin
          state_d = rnd_result;
          if (round_idx == LAST_RND) begin
            fsm_d = FSM_DONE;
          end else begin
            round_idx_d = round_idx + 4'd1;
            fsm_d       = FSM_ISSUE;
          end
        end
      end
      FSM_DONE: begin
        if (out_ready) begin
          fsm_d       = FSM_IDLE;
          state_d     = '0;
          round_idx_d = 4'd0;
        end
      end
      default: fsm_d = FSM_IDLE;
    endcase
    // Cancel wins over every other transition, including the output handshake.
    if (abort && fsm_q != FSM_IDLE) begin
      fsm_d       = FSM_IDLE;
      state_d     = '0;
      round_idx_d = 4'd0;
      wait_cnt_d  = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fsm_q      <= FSM_IDLE;
      state_q    <= '0;
      round_idx  <= 4'd0;
      wait_cnt_q <= 4'd0;
      rnd_last   <= 1'b0;
    end else begin
      fsm_q      <= fsm_d;
      state_q    <= state_d;
      round_idx  <= round_idx_d;
      wait_cnt_q <= wait_cnt_d;
      rnd_last   <= (round_idx_d == LAST_RND);
    end
  end

  // Fed from the next-round index so the key lands in the same cycle as state_q.
  aes_round_key_sel u_key_sel (
    .clk          (clk),
    .rst          (rst),
    .expanded_key (expanded_key),
    .idx          (round_idx_d),
    .rnd_key      (rnd_key)
  );

  assign in_ready   = (fsm_q == FSM_IDLE) && !rst;
  assign busy       = (fsm_q != FSM_IDLE);
  assign out_valid  = (fsm_q == FSM_DONE);
  assign rnd_valid  = (fsm_q == FSM_ISSUE);
  assign rnd_state  = state_q;
  assign ciphertext = state_q;

endmodule
`default_nettype wire
